// File: rtl/iec_drive_sd_arb.sv
// Round-robin arbiter sharing one host SD block port among up to 8 IEC drives.
// Latches the winning request, tracks the host ack handshake, times out silent hosts.
module iec_drive_sd_arb #(
    parameter int DRIVES = 4,
    parameter int LBA_W  = 32,
    parameter int CNT_W  = 6,
    parameter int TMO_W  = 16
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [DRIVES-1:0]         req_rd,
    input  logic [DRIVES-1:0]         req_wr,
    input  logic [DRIVES*LBA_W-1:0]   req_lba,
    input  logic [DRIVES*CNT_W-1:0]   req_blk_cnt,
    input  logic [DRIVES*8-1:0]       req_buff_din,
    input  logic [DRIVES-1:0]         img_mounted,
    output logic [DRIVES-1:0]         req_ack,
    output logic [DRIVES-1:0]         req_err,
    output logic [DRIVES-1:0]         grant,
    output logic                      busy,
    output logic [LBA_W-1:0]          sd_lba,
    output logic [CNT_W-1:0]          sd_blk_cnt,
    output logic                      sd_rd,
    output logic                      sd_wr,
    input  logic                      sd_ack,
    output logic [7:0]                sd_buff_din
);

    localparam int N = (DRIVES < 1) ? 1 : ((DRIVES > 8) ? 8 : DRIVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DRIVES-1:0]    grant_q, grant_d;
    logic [DRIVES-1:0]    err_q, err_d;
    logic [7:0]           stale_q, stale_d;
    logic [7:0]           stale_set;
    logic [2:0]           ptr_q, ptr_d;
    logic [2:0]           win_q, win_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [LBA_W-1:0]     lba_q, lba_d;
    logic [CNT_W-1:0]     blk_q, blk_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;

    logic [7:0]           rd8, wr8, mnt8, elig8;
    logic                 found;
    logic [2:0]           pick;
    logic [3:0]           idx;

    // Fixed 8-wide views of the per-drive inputs so 3-bit indices stay in range.
    always_comb begin
        rd8   = '0;
        wr8   = '0;
        mnt8  = '0;
        elig8 = '0;
        for (int i = 0; i < N; i++) begin
            rd8[i]   = req_rd[i];
            wr8[i]   = req_wr[i];
            mnt8[i]  = img_mounted[i];
            elig8[i] = (req_rd[i] | req_wr[i]) & ~stale_q[i];
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(N)) begin
                idx = idx - 4'(N);
            end
            if (!found && elig8[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        err_d     = '0;
        stale_set = '0;
        ptr_d     = ptr_q;
        win_d     = win_q;
        tmo_d     = tmo_q;
        lba_d     = lba_q;
        blk_d     = blk_q;
        rd_d      = rd_q;
        wr_d      = wr_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d = pick;
                    for (int i = 0; i < N; i++) begin
                        grant_d[i] = (pick == 3'(i));
                    end
                    lba_d   = req_lba[int'(pick)*LBA_W +: LBA_W];
                    blk_d   = req_blk_cnt[int'(pick)*CNT_W +: CNT_W];
                    wr_d    = wr8[pick];
                    rd_d    = rd8[pick] & ~wr8[pick];
                    tmo_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_XFER;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == {TMO_W{1'b1}}) begin
                        rd_d = 1'b0;
                        wr_d = 1'b0;
                        for (int i = 0; i < N; i++) begin
                            err_d[i] = (win_q == 3'(i));
                        end
                        stale_set[win_q] = 1'b1;
                        state_d          = S_DONE;
                    end
                end
            end
            S_XFER: begin
                if (!sd_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                stale_set[win_q] = 1'b1;
                ptr_d   = (win_q == 3'(N - 1)) ? 3'd0 : win_q + 3'd1;
                grant_d = '0;
                tmo_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A drive stays masked until it drops its request or remounts; a new set wins over a clear.
    always_comb begin
        stale_d = '0;
        for (int i = 0; i < 8; i++) begin
            stale_d[i] = stale_set[i] |
                         (stale_q[i] & ~((~rd8[i] & ~wr8[i]) | mnt8[i]));
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            err_q   <= '0;
            stale_q <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            tmo_q   <= '0;
            lba_q   <= '0;
            blk_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            stale_q <= stale_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            tmo_q   <= tmo_d;
            lba_q   <= lba_d;
            blk_q   <= blk_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        sd_buff_din = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                sd_buff_din = req_buff_din[i*8 +: 8];
            end
        end
    end

    assign grant      = grant_q;
    assign req_ack    = grant_q & {DRIVES{sd_ack}};
    assign req_err    = err_q;
    assign busy       = (state_q != S_IDLE);
    assign sd_lba     = lba_q;
    assign sd_blk_cnt = blk_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;

endmodule

// File: tb/tb_iec_drive_sd_arb.sv
// Randomised scoreboard bench for iec_drive_sd_arb: expected host transactions are
// queued when requests are raised and popped by a monitor whenever sd_rd/sd_wr rises.
module tb_iec_drive_sd_arb;

    localparam int DRIVES  = 4;
    localparam int LBA_W   = 32;
    localparam int CNT_W   = 6;
    localparam int TMO_W   = 4;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    logic                     clk_sys = 1'b0;
    logic                     reset_n = 1'b0;
    logic [DRIVES-1:0]        req_rd = '0;
    logic [DRIVES-1:0]        req_wr = '0;
    logic [DRIVES*LBA_W-1:0]  req_lba = '0;
    logic [DRIVES*CNT_W-1:0]  req_blk_cnt = '0;
    logic [DRIVES*8-1:0]      req_buff_din = '0;
    logic [DRIVES-1:0]        img_mounted = '0;
    logic [DRIVES-1:0]        req_ack;
    logic [DRIVES-1:0]        req_err;
    logic [DRIVES-1:0]        grant;
    logic                     busy;
    logic [LBA_W-1:0]         sd_lba;
    logic [CNT_W-1:0]         sd_blk_cnt;
    logic                     sd_rd;
    logic                     sd_wr;
    logic                     sd_ack = 1'b0;
    logic [7:0]               sd_buff_din;

    iec_drive_sd_arb #(
        .DRIVES(DRIVES),
        .LBA_W (LBA_W),
        .CNT_W (CNT_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_lba     (req_lba),
        .req_blk_cnt (req_blk_cnt),
        .req_buff_din(req_buff_din),
        .img_mounted (img_mounted),
        .req_ack     (req_ack),
        .req_err     (req_err),
        .grant       (grant),
        .busy        (busy),
        .sd_lba      (sd_lba),
        .sd_blk_cnt  (sd_blk_cnt),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_din (sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int               drv;
        logic [LBA_W-1:0] lba;
        logic [CNT_W-1:0] cnt;
        logic             rd;
        logic             wr;
        logic [7:0]       din;
        logic             tmo;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Behavioural view of the arbiter: only the round-robin start point is remembered.
    int model_ptr = 0;

    logic [DRIVES-1:0] active   = '0;
    logic [DRIVES-1:0] hold_err = '0;
    logic [DRIVES-1:0] prev_ack = '0;
    logic              tmo_mode = 1'b0;
    logic              host_en  = 1'b0;
    int                h_state  = 0;
    int                h_cnt    = 0;

    function automatic logic [DRIVES-1:0] onehot(input int d);
        logic [DRIVES-1:0] v;
        v    = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One clock: drives react to ack/err, granted drives scramble their LBA, host answers.
    task automatic step();
        logic [DRIVES-1:0] ack_now;
        logic [DRIVES-1:0] err_now;
        logic [DRIVES-1:0] g_now;
        @(posedge clk_sys);
        #1;
        ack_now = req_ack;
        err_now = req_err;
        g_now   = grant;
        for (int i = 0; i < DRIVES; i++) begin
            if (active[i]) begin
                if ((prev_ack[i] && !ack_now[i]) || (err_now[i] && !hold_err[i])) begin
                    req_rd[i] = 1'b0;
                    req_wr[i] = 1'b0;
                    active[i] = 1'b0;
                end else if (g_now[i]) begin
                    req_lba[i*LBA_W +: LBA_W]     = $urandom();
                    req_blk_cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom());
                end
            end
        end
        prev_ack = ack_now;
        if (host_en && !tmo_mode) begin
            case (h_state)
                0: if (sd_rd || sd_wr) begin
                       h_cnt   = $urandom_range(0, 3);
                       h_state = 1;
                   end
                1: if (h_cnt == 0) begin
                       sd_ack  = 1'b1;
                       h_cnt   = $urandom_range(1, 4);
                       h_state = 2;
                   end else begin
                       h_cnt--;
                   end
                default: if (h_cnt <= 1) begin
                       sd_ack  = 1'b0;
                       h_state = 0;
                   end else begin
                       h_cnt--;
                   end
            endcase
        end
    endtask

    task automatic pushExp(input int idx, input logic tmo);
        exp_t e;
        e.drv = idx;
        e.lba = req_lba[idx*LBA_W +: LBA_W];
        e.cnt = req_blk_cnt[idx*CNT_W +: CNT_W];
        e.wr  = req_wr[idx];
        e.rd  = req_rd[idx] & ~req_wr[idx];
        e.din = req_buff_din[idx*8 +: 8];
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // op: 0 random, 1 read, 2 write, 3 read+write together.
    task automatic applyStimulus(input logic [3:0] mask, input int op, input logic tmo, input logic hold);
        int o;
        int idx;
        int last;
        last     = model_ptr;
        tmo_mode = tmo;
        for (int i = 0; i < DRIVES; i++) begin
            if (mask[i]) begin
                o = (op == 0) ? int'($urandom_range(1, 3)) : op;
                req_rd[i]                     = (o == 1) || (o == 3);
                req_wr[i]                     = (o == 2) || (o == 3);
                req_lba[i*LBA_W +: LBA_W]     = $urandom();
                req_blk_cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom());
                req_buff_din[i*8 +: 8]        = 8'($urandom());
                active[i]                     = 1'b1;
                hold_err[i]                   = hold;
            end
        end
        for (int k = 0; k < DRIVES; k++) begin
            idx = (model_ptr + k) % DRIVES;
            if (mask[idx]) begin
                pushExp(idx, tmo);
                last = idx;
            end
        end
        model_ptr = (last + 1) % DRIVES;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((active != '0 || busy) && n < 1500) begin
            step();
            n++;
        end
        checkOutput("round_complete", 64'({active != '0, busy}), 64'(0));
        step();
        step();
        checkOutput("idle_busy", 64'(busy), 64'(0));
        checkOutput("idle_grant", 64'(grant), 64'(0));
        checkOutput("idle_buff_din", 64'(sd_buff_din), 64'(0));
        checkOutput("idle_rdwr", 64'({sd_rd, sd_wr}), 64'(0));
        checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic ackGlitch();
        host_en = 1'b0;
        sd_ack  = 1'b1;
        step();
        #1;
        checkOutput("glitch_req_ack", 64'(req_ack), 64'(0));
        step();
        checkOutput("glitch_busy", 64'(busy), 64'(0));
        checkOutput("glitch_grant", 64'(grant), 64'(0));
        sd_ack  = 1'b0;
        h_state = 0;
        host_en = 1'b1;
        step();
    endtask

    // Monitor: pops an expectation on every rising host request.
    logic prev_act = 1'b0;
    logic in_txn   = 1'b0;
    logic ack_seen = 1'b0;
    logic err_next = 1'b0;
    logic act;
    int   high     = 0;
    exp_t cur;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_act = 1'b0;
            in_txn   = 1'b0;
            err_next = 1'b0;
        end else begin
            act = sd_rd | sd_wr;
            checkOutput("rd_wr_exclusive", 64'(sd_rd & sd_wr), 64'(0));
            if (err_next) begin
                checkOutput("req_err_single", 64'(req_err), 64'(0));
                err_next = 1'b0;
            end
            if (act && !prev_act) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_issue actual grant=0x%0h required no issue", grant);
                end else begin
                    cur      = exp_q.pop_front();
                    in_txn   = 1'b1;
                    ack_seen = 1'b0;
                    high     = 0;
                    checkOutput("issue_grant", 64'(grant), 64'(onehot(cur.drv)));
                    checkOutput("issue_blk_cnt", 64'(sd_blk_cnt), 64'(cur.cnt));
                    checkOutput("issue_rd", 64'(sd_rd), 64'(cur.rd));
                    checkOutput("issue_wr", 64'(sd_wr), 64'(cur.wr));
                    checkOutput("issue_buff_din", 64'(sd_buff_din), 64'(cur.din));
                    checkOutput("issue_busy", 64'(busy), 64'(1));
                end
            end
            if (act && in_txn) begin
                high++;
                checkOutput("sd_lba", 64'(sd_lba), 64'(cur.lba));
            end
            if (sd_ack && in_txn && !ack_seen) begin
                ack_seen = 1'b1;
                checkOutput("req_ack_route", 64'(req_ack), 64'(onehot(cur.drv)));
                checkOutput("ack_buff_din", 64'(sd_buff_din), 64'(cur.din));
            end
            if (!act && prev_act && in_txn) begin
                if (cur.tmo) begin
                    checkOutput("tmo_length", 64'(high), 64'(TMO_CYC));
                    checkOutput("req_err_pulse", 64'(req_err), 64'(onehot(cur.drv)));
                    err_next = 1'b1;
                end else begin
                    checkOutput("req_err_quiet", 64'(req_err), 64'(0));
                end
                in_txn = 1'b0;
            end
            prev_act = act;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic [3:0] mask;
        logic tmo;

        $display("[TB] start");
        sd_ack = 1'b1;
        #12;
        checkOutput("reset_grant", 64'(grant), 64'(0));
        checkOutput("reset_req_ack", 64'(req_ack), 64'(0));
        checkOutput("reset_rdwr", 64'({sd_rd, sd_wr}), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_err", 64'(req_err), 64'(0));
        checkOutput("reset_lba_cnt", 64'({sd_lba, sd_blk_cnt}), 64'(0));
        sd_ack = 1'b0;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        host_en = 1'b1;
        step();

        applyStimulus(4'b0001, 1, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(4'b0100, 3, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(4'b1010, 1, 1'b0, 1'b0);
        waitIdle();
        ackGlitch();

        // Timed-out drive keeps requesting: masked until it remounts.
        applyStimulus(4'b0001, 1, 1'b1, 1'b1);
        n = 0;
        while (!req_err[0] && n < 100) begin
            step();
            n++;
        end
        checkOutput("tmo_err_seen", 64'(req_err[0]), 64'(1));
        repeat (30) step();
        checkOutput("stale_busy", 64'(busy), 64'(0));
        checkOutput("stale_grant", 64'(grant), 64'(0));
        checkOutput("stale_queue", 64'(exp_q.size()), 64'(0));
        img_mounted[0] = 1'b1;
        pushExp(0, 1'b1);
        model_ptr = 1;
        step();
        img_mounted[0] = 1'b0;
        n = 0;
        while (!req_err[0] && n < 100) begin
            step();
            n++;
        end
        checkOutput("remount_err_seen", 64'(req_err[0]), 64'(1));
        req_rd[0]   = 1'b0;
        req_wr[0]   = 1'b0;
        active[0]   = 1'b0;
        hold_err[0] = 1'b0;
        tmo_mode    = 1'b0;
        waitIdle();

        for (int r = 0; r < 30; r++) begin
            mask = 4'($urandom_range(1, 15));
            tmo  = ($urandom_range(0, 4) == 0);
            applyStimulus(mask, 0, tmo, 1'b0);
            waitIdle();
            if (r % 4 == 3) begin
                ackGlitch();
            end
        end

        // Reset while the host is mid-transfer.
        host_en = 1'b0;
        h_state = 0;
        applyStimulus(4'b0010, 1, 1'b0, 1'b0);
        n = 0;
        while (!sd_rd && n < 20) begin
            step();
            n++;
        end
        sd_ack = 1'b1;
        step();
        step();
        checkOutput("xfer_req_ack", 64'(req_ack), 64'(onehot(1)));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_grant", 64'(grant), 64'(0));
        checkOutput("async_rst_req_ack", 64'(req_ack), 64'(0));
        checkOutput("async_rst_busy", 64'(busy), 64'(0));
        checkOutput("async_rst_rdwr", 64'({sd_rd, sd_wr}), 64'(0));
        model_ptr = 0;
        req_rd    = '0;
        req_wr    = '0;
        active    = '0;
        prev_ack  = '0;
        sd_ack    = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        host_en = 1'b1;
        step();
        applyStimulus(4'b1100, 0, 1'b0, 1'b0);
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iec_drive_sd_arb.md
Name: iec_drive_sd_arb

Overview:
- Parametrised arbiter that shares one host SD block port among up to 8 IEC drive instances. It replaces the per-drive sd_rd/sd_wr/sd_lba fan-out.
- Uses round-robin grant, latches the winning request, and tracks the host ack handshake.
- Routes ack and write data back to the granted drive only. Adds an ack timeout and stale-request masking.
- Sits between the drive selector block and the host SD interface, in the clk_sys domain.

Parameters:
- DRIVES, 4, number of drive channels, legal 1..8.
- LBA_W, 32, LBA width.
- CNT_W, 6, block-count width.
- TMO_W, 16, timeout counter width. Timeout fires after 2^TMO_W-1 cycles without ack rise.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_rd  in  DRIVES  per-drive read request (level, held until that drive's req_ack falls).
- req_wr  in  DRIVES  per-drive write request (level).
- req_lba  in  DRIVES*LBA_W  flattened per-drive LBA; drive i uses bits [i*LBA_W +: LBA_W].
- req_blk_cnt  in  DRIVES*CNT_W  flattened per-drive block count (value = blocks-1).
- req_buff_din  in  DRIVES*8  flattened per-drive write data.
- img_mounted  in  DRIVES  per-drive mount strobe.
- req_ack  out  DRIVES  per-drive ack = sd_ack AND grant[i] (combinational from registered grant).
- req_err  out  DRIVES  one-cycle pulse on timeout for the granted drive.
- grant  out  DRIVES  registered one-hot grant, 0 when idle.
- busy  out  1  high in any state other than IDLE.
- sd_lba  out  LBA_W  latched LBA.
- sd_blk_cnt  out  CNT_W  latched block count.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host ack (level).
- sd_buff_din  out  8  req_buff_din of the granted drive; 0 when grant=0.

Behaviour:
Reset (reset_n low, asynchronous):
- state=IDLE; grant, sd_rd, sd_wr, req_err, busy all 0; sd_lba, sd_blk_cnt 0.
- Round-robin pointer ptr=0; stale mask=0; timeout counter=0.
- A reset mid-transfer drops sd_rd/sd_wr immediately. No completion is reported.

Eligibility: eligible[i] = (req_rd[i] | req_wr[i]) & ~stale[i].

IDLE:
- If any eligible, pick the first eligible index searching ptr, ptr+1, ... mod DRIVES.
- Next edge: grant=onehot(winner), latch lba and blk_cnt.
- sd_wr=req_wr[winner]; sd_rd=req_rd[winner] & ~req_wr[winner]. Write wins when both are set.
- Go to ISSUE. Latency is 1 cycle from sampled request to sd_rd/sd_wr high.

ISSUE:
- Hold sd_rd/sd_wr and increment the timeout counter each cycle.
- sd_ack high: clear sd_rd/sd_wr, go to XFER.
- Counter reaches all-ones before ack:
  - clear sd_rd/sd_wr;
  - pulse req_err[winner] for 1 cycle;
  - set stale[winner];
  - go to DONE.

XFER:
- Wait for sd_ack low, then go to DONE.
- No timeout in XFER.

DONE (1 cycle):
- Set stale[winner].
- ptr = (winner+1) mod DRIVES, with wrap from DRIVES-1 to 0.
- Clear grant and counter; go to IDLE.

Stale mask:
- stale[i] clears on any cycle where req_rd[i]=req_wr[i]=0. This prevents re-granting a drive that has not yet released its completed request.
- If a clear and a set of stale[i] occur in the same cycle, set wins.

img_mounted[i]:
- Clears stale[i].
- Does not abort an active grant; an in-flight host transfer always completes.

Other rules:
- Lba/cnt changes on a granted drive after latch are ignored until the next grant.
- DRIVES=1 degenerates to a pass-through with 1-cycle request latency; ptr is constant 0.
- DRIVES>8 or <1 is clamped to the range 1..8.
- Exactly one of sd_rd/sd_wr is high, and only in ISSUE.

Test Plan:
- Single read: drive 0 raises req_rd, lba=0x123, cnt=0. Sd_rd rises 1 cycle later with sd_lba=0x123 and grant=0001. Ack high 3 cycles: req_ack[0] mirrors it. DONE follows, then busy=0.
- Round-robin: drives 1 and 3 request together from reset (ptr=0). Grant order is 1 then 3. Drive 1 re-requesting immediately is granted only after 3, and only once its request has dropped low.
- Write priority: drive 2 asserts req_rd and req_wr together. Sd_wr=1, sd_rd=0. Sd_buff_din equals drive 2's data while granted, and is 0 afterwards.
- Timeout (TMO_W=4): no ack is returned. Sd_rd drops after 15 cycles and req_err[0] pulses once. Drive 0 holding its request is not re-granted until it drops or img_mounted[0] strobes.
- Reset mid-XFER: assert reset_n low during ack-high. All outputs go to 0 asynchronously. After release, a pending request from drive 2 is granted first search from ptr=0.
- Ack glitch: sd_ack high while state=IDLE. req_ack stays all zero and no state change occurs.
